// File: rtl/waterfall_capture_pkg.sv
// Shared definitions for the waterfall capture block.
//   state_t   : capture FSM encoding
//   scale_mag : magnitude-to-pixel scaling (right shift, then saturate)
package waterfall_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,  // counting DFT updates
    WAIT_RD = 2'd1,  // row due, waiting for an idle DFT with nothing pending
    READ    = 2'd2,  // sweeping bin addresses and capturing magnitudes
    COMMIT  = 2'd3   // publish the freshly written row
  } state_t;

  // Returns min(mag >> shift, 2^pix_w - 1). Valid for pix_w < 32.
  function automatic logic [31:0] scale_mag(input logic [31:0] mag,
                                            input int          shift,
                                            input int          pix_w);
    logic [31:0] shifted;
    logic [31:0] max_pix;
    shifted = mag >> shift;
    max_pix = (32'd1 << pix_w) - 32'd1;
    return (shifted > max_pix) ? max_pix : shifted;
  endfunction

endpackage

// File: rtl/waterfall_capture_fb.sv
// Waterfall frame buffer: simple dual-port RAM.
//   clk   : clock
//   we    : write enable
//   waddr : write address {row, column}
//   wdata : pixel to write
//   raddr : read address {row, column}
//   rdata : registered read data, one cycle after raddr
module waterfall_capture_fb #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array and its read register have no reset; a reset here would
  // stop the tools from mapping this onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/waterfall_capture.sv
// Waterfall capture: gates sample strobes into sliding-DFT update requests and,
// every UPDATES_PER_ROW updates, sweeps all bins into one row of a circular
// frame buffer. The display side reads by logical row (0 = newest).
//   clk, reset_n   : clock, asynchronous active-low reset
//   samp_strobe    : new sample present at the DFT input
//   sdft_ready     : DFT idle
//   sdft_start     : DFT update request (one cycle)
//   sdft_read      : DFT read request
//   sdft_bin_addr  : bin address to the DFT
//   sdft_bin_out   : DFT magnitude, READ_LAT cycles after the address
//   disp_row/col   : display lookup, logical row and column
//   disp_pix       : pixel, one cycle after disp_row/col
//   row_done       : one-cycle pulse when a row commits
//   overrun        : sticky, a strobe was lost
module waterfall_capture
  import waterfall_capture_pkg::*;
#(
  parameter int FREQ_W          = 16,
  parameter int LIMIT_BINS      = 32,
  parameter int ROWS            = 32,
  parameter int PIX_W           = 8,
  parameter int MAG_SHIFT       = 4,
  parameter int UPDATES_PER_ROW = 64,
  parameter int READ_LAT        = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          samp_strobe,
  input  logic                          sdft_ready,
  output logic                          sdft_start,
  output logic                          sdft_read,
  output logic [$clog2(LIMIT_BINS)-1:0] sdft_bin_addr,
  input  logic [FREQ_W-1:0]             sdft_bin_out,
  input  logic [$clog2(ROWS)-1:0]       disp_row,
  input  logic [$clog2(LIMIT_BINS)-1:0] disp_col,
  output logic [PIX_W-1:0]              disp_pix,
  output logic                          row_done,
  output logic                          overrun
);

  localparam int COL_W   = $clog2(LIMIT_BINS);
  localparam int ROW_W   = $clog2(ROWS);
  localparam int UPD_W   = $clog2(UPDATES_PER_ROW + 1);
  localparam int VR_W    = $clog2(ROWS + 1);
  localparam int RD_LAST = LIMIT_BINS + READ_LAT - 1;  // last READ cycle index
  localparam int RD_W    = $clog2(RD_LAST + 2);

  localparam logic [UPD_W-1:0] UPD_MAX = UPD_W'(UPDATES_PER_ROW);
  localparam logic [VR_W-1:0]  VR_MAX  = VR_W'(ROWS);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(LIMIT_BINS - 1);

  state_t            state_q, state_d;
  logic              pending_q;
  logic              overrun_q;
  logic [UPD_W-1:0]  upd_cnt_q;
  logic [ROW_W-1:0]  wr_row_q;
  logic [VR_W-1:0]   valid_rows_q;
  logic [RD_W-1:0]   rd_cnt_q;
  logic [ROW_W-1:0]  disp_row_q;

  logic              start_ok;
  logic              arm;
  logic              wr_en;
  logic [COL_W-1:0]  wr_col;
  logic [PIX_W-1:0]  wr_pix;
  logic [ROW_W-1:0]  phys_row;
  logic [PIX_W-1:0]  ram_q;

  // A start can only go out while nothing is being read; this alone keeps
  // start and read mutually exclusive, since arming requires !pending.
  assign start_ok = pending_q && sdft_ready && (state_q == IDLE || state_q == WAIT_RD);

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    arm           = 1'b0;
    sdft_bin_addr = '0;
    wr_en         = 1'b0;
    wr_col        = '0;
    unique case (state_q)
      IDLE:    if (upd_cnt_q == UPD_MAX) state_d = WAIT_RD;
      WAIT_RD: if (sdft_ready && !pending_q) begin
                 arm     = 1'b1;
                 state_d = READ;
               end
      READ: begin
        // Address k on cycle k, then held on the last bin while the
        // pipeline drains; capture trails the address by READ_LAT.
        sdft_bin_addr = (rd_cnt_q >= RD_W'(LIMIT_BINS - 1)) ? COL_MAX
                                                             : rd_cnt_q[COL_W-1:0];
        wr_en  = (rd_cnt_q >= RD_W'(READ_LAT));
        wr_col = COL_W'(rd_cnt_q - RD_W'(READ_LAT));
        if (rd_cnt_q == RD_W'(RD_LAST)) state_d = COMMIT;
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign sdft_start = start_ok;
  assign sdft_read  = arm || (state_q == READ);
  assign row_done   = (state_q == COMMIT);
  assign overrun    = overrun_q;
  assign wr_pix     = PIX_W'(scale_mag(32'(sdft_bin_out), MAG_SHIFT, PIX_W));

  // NOTE: sequential state uses non-blocking assignments so every register
  // here sees the pre-edge value of every other one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      pending_q    <= 1'b0;
      overrun_q    <= 1'b0;
      upd_cnt_q    <= '0;
      wr_row_q     <= ROW_W'(ROWS - 1);
      valid_rows_q <= '0;
      rd_cnt_q     <= '0;
      disp_row_q   <= '0;
    end else begin
      state_q    <= state_d;
      disp_row_q <= disp_row;
      // A strobe on the issuing edge simply re-arms pending.
      pending_q  <= samp_strobe || (pending_q && !start_ok);
      if (samp_strobe && pending_q && !start_ok) overrun_q <= 1'b1;

      if (state_q == IDLE && upd_cnt_q == UPD_MAX) begin
        upd_cnt_q <= start_ok ? UPD_W'(1) : '0;
      end else if (start_ok && upd_cnt_q != UPD_MAX) begin
        upd_cnt_q <= upd_cnt_q + UPD_W'(1);
      end

      rd_cnt_q <= (state_q == READ) ? rd_cnt_q + RD_W'(1) : '0;

      if (state_q == COMMIT) begin
        wr_row_q <= wr_row_q + ROW_W'(1);
        if (valid_rows_q != VR_MAX) valid_rows_q <= valid_rows_q + VR_W'(1);
      end
    end
  end

  // Newest row sits at wr_row; older rows are further back, modulo ROWS.
  assign phys_row = wr_row_q - disp_row;

  waterfall_capture_fb #(
    .DEPTH  (ROWS * LIMIT_BINS),
    .DATA_W (PIX_W),
    .ADDR_W (ROW_W + COL_W)
  ) u_fb (
    .clk   (clk),
    .we    (wr_en),
    .waddr ({wr_row_q + ROW_W'(1), wr_col}),
    .wdata (wr_pix),
    .raddr ({phys_row, disp_col}),
    .rdata (ram_q)
  );

  // Rows never written read as black.
  assign disp_pix = (VR_W'(disp_row_q) < valid_rows_q) ? ram_q : '0;

endmodule

// File: tb/tb_waterfall_capture.sv
// Self-checking bench for waterfall_capture with a behavioural sliding-DFT
// model (ready low for 8 cycles after each start, READ_LAT=2 read pipeline)
// and a display scoreboard of expected pixels.
module tb_waterfall_capture;

  localparam int FREQ_W = 16;
  localparam int BINS   = 32;
  localparam int ROWS   = 32;
  localparam int PIX_W  = 8;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              samp_strobe = 1'b0;
  logic              sdft_ready = 1'b1;
  logic              sdft_start, sdft_read, row_done, overrun;
  logic [4:0]        sdft_bin_addr;
  logic [FREQ_W-1:0] sdft_bin_out = '0;
  logic [4:0]        disp_row = '0;
  logic [4:0]        disp_col = '0;
  logic [PIX_W-1:0]  disp_pix;

  always #5 clk = ~clk;

  waterfall_capture #(
    .FREQ_W(FREQ_W), .LIMIT_BINS(BINS), .ROWS(ROWS), .PIX_W(PIX_W),
    .MAG_SHIFT(4), .UPDATES_PER_ROW(64), .READ_LAT(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .samp_strobe(samp_strobe),
    .sdft_ready(sdft_ready), .sdft_start(sdft_start), .sdft_read(sdft_read),
    .sdft_bin_addr(sdft_bin_addr), .sdft_bin_out(sdft_bin_out),
    .disp_row(disp_row), .disp_col(disp_col), .disp_pix(disp_pix),
    .row_done(row_done), .overrun(overrun)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // ---------------- DFT model and bus monitor ----------------
  int   mag_mode = 0;   // 0: addr*100, 1: 0xFFFF, 2: row_val*16
  int   row_val  = 0;
  bit   ready_en = 1'b1;
  int   cyc = 0, start_cnt = 0, row_done_cnt = 0, read_rise_cnt = 0;
  int   overlap_cnt = 0, long_start_cnt = 0, done_gap_cnt = 0;
  int   last_start_cyc = -1, last_done_cyc = -1;
  logic [4:0] addr_log[$];

  function automatic logic [15:0] mag_of(input logic [4:0] a);
    case (mag_mode)
      0:       return 16'(a * 100);
      1:       return 16'hFFFF;
      default: return 16'(row_val * 16);
    endcase
  endfunction

  function automatic logic [7:0] exp_pix(input int mag);
    int s;
    s = mag >> 4;
    return (s > 255) ? 8'd255 : 8'(s);
  endfunction

  initial begin : dft_model
    bit         s, r, prev_s, prev_r;
    logic [4:0] a, a_hist;
    int         busy;
    prev_s = 0; prev_r = 0; a_hist = '0; busy = 0;
    forever begin
      @(negedge clk);
      cyc++;
      s = sdft_start; r = sdft_read; a = sdft_bin_addr;
      if (s) begin
        start_cnt++;
        last_start_cyc = cyc;
        if (prev_s) long_start_cnt++;
      end
      if (s && r) overlap_cnt++;
      if (r && !prev_r) begin
        read_rise_cnt++;
        addr_log.delete();
      end
      if (r) addr_log.push_back(a);
      if (row_done) begin
        row_done_cnt++;
        last_done_cyc = cyc;
        if (!prev_r) done_gap_cnt++;
      end
      prev_s = s; prev_r = r;
      @(posedge clk); #1;
      sdft_bin_out = mag_of(a_hist);   // address from two cycles back
      a_hist       = a;
      if (s) busy = 8;
      else if (busy > 0) busy--;
      sdft_ready = ready_en && (busy == 0);
    end
  end

  // ---------------- display scoreboard ----------------
  logic [7:0] exp_q[$];
  string      tag_q[$];
  bit         disp_vld = 1'b0;

  initial begin : disp_mon
    bit vld_prev;
    vld_prev = 0;
    forever begin
      @(negedge clk);
      if (vld_prev) begin
        check("sb_nonempty", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check(tag_q.pop_front(), disp_pix, exp_q.pop_front());
      end
      vld_prev = disp_vld;
    end
  end

  task automatic disp_read(input int row, input int col, input logic [7:0] exp);
    @(posedge clk); #1;
    disp_row = row[4:0];
    disp_col = col[4:0];
    disp_vld = 1'b1;
    exp_q.push_back(exp);
    tag_q.push_back($sformatf("pix_r%0d_c%0d", row, col));
  endtask

  task automatic disp_done();
    @(posedge clk); #1;
    disp_vld = 1'b0;
    @(posedge clk);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic strobe();
    @(posedge clk); #1; samp_strobe = 1'b1;
    @(posedge clk); #1; samp_strobe = 1'b0;
  endtask

  // Strobe every 12 cycles until the capture FSM starts a read sweep.
  task automatic strobe_until_read();
    int rise0, n;
    rise0 = read_rise_cnt; n = 0;
    while (read_rise_cnt == rise0 && n < 200) begin
      strobe();
      repeat (11) @(posedge clk);
      n++;
    end
    check("read_started", read_rise_cnt - rise0, 1);
  endtask

  task automatic wait_done(input int done0);
    int t;
    t = 0;
    while (row_done_cnt == done0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    check("row_done_seen", row_done_cnt - done0, 1);
  endtask

  task automatic run_row();
    int done0;
    done0 = row_done_cnt;
    strobe_until_read();
    wait_done(done0);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int s0, d0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_start",    sdft_start, 0);
    check("rst_read",     sdft_read, 0);
    check("rst_addr",     sdft_bin_addr, 0);
    check("rst_pix",      disp_pix, 0);
    check("rst_row_done", row_done, 0);
    check("rst_overrun",  overrun, 0);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);

    // Row 1: magnitude = addr*100.
    mag_mode = 0;
    run_row();
    check("starts_row1",   start_cnt, 64);
    check("read_len",      addr_log.size(), 35);
    if (addr_log.size() == 35) begin
      for (int k = 0; k < BINS; k++) check($sformatf("addr_%0d", k), addr_log[1 + k], k);
      check("addr_drain0", addr_log[33], 31);
      check("addr_drain1", addr_log[34], 31);
    end
    check("row_done_cnt1", row_done_cnt, 1);
    check("done_after_read", done_gap_cnt, 0);
    check("start_width",   long_start_cnt, 0);
    check("overrun_row1",  overrun, 0);
    for (int k = 0; k < BINS; k++) disp_read(0, k, exp_pix(k * 100));
    disp_read(1, 0, 8'd0);
    disp_read(31, 3, 8'd0);
    disp_done();

    // Row 2: saturation.
    mag_mode = 1;
    run_row();
    for (int k = 0; k < BINS; k++) disp_read(0, k, 8'd255);
    disp_read(1, 3, 8'd18);
    disp_read(1, 31, 8'd193);
    disp_read(2, 0, 8'd0);
    disp_done();

    // Overrun: two strobes two cycles apart while the DFT is busy.
    @(posedge clk); #1; ready_en = 1'b0;
    repeat (3) @(posedge clk);
    s0 = start_cnt;
    #1; samp_strobe = 1'b1;
    @(posedge clk); #1; samp_strobe = 1'b0;
    @(posedge clk); #1; samp_strobe = 1'b1;
    @(posedge clk); #1; samp_strobe = 1'b0;
    @(posedge clk); #1;
    check("overrun_set", overrun, 1);
    repeat (20) @(posedge clk);
    check("no_start_busy", start_cnt - s0, 0);
    #1; ready_en = 1'b1;
    repeat (20) @(posedge clk);
    check("one_start", start_cnt - s0, 1);
    check("overrun_sticky", overrun, 1);

    // Strobe during READ: held until the first IDLE cycle after COMMIT.
    mag_mode = 2; row_val = 7;
    d0 = row_done_cnt;
    strobe_until_read();
    strobe();
    s0 = start_cnt;
    wait_done(d0);
    check("no_start_in_read", start_cnt - s0, 0);
    repeat (3) @(posedge clk);
    check("start_after_commit", start_cnt - s0, 1);
    check("start_cycle", last_start_cyc - last_done_cyc, 1);
    check("no_overlap", overlap_cnt, 0);

    // 33 rows, row r magnitude r*16 -> pixel r; wraps the frame buffer.
    for (int r = 0; r <= 32; r++) begin
      row_val = r;
      run_row();
    end
    disp_read(0, 0, 8'd32);
    disp_read(0, 31, 8'd32);
    disp_read(1, 4, 8'd31);
    disp_read(16, 10, 8'd16);
    disp_read(31, 5, 8'd1);
    disp_done();
    check("no_overlap_all", overlap_cnt, 0);
    check("start_width_all", long_start_cnt, 0);

    // Reset in the middle of a read sweep.
    row_val = 40;
    strobe_until_read();
    repeat (5) @(posedge clk);
    #2;
    check("read_before_rst", sdft_read, 1);
    d0 = row_done_cnt;
    reset_n = 1'b0;
    #1;
    check("rst_mid_read", sdft_read, 0);
    check("rst_mid_addr", sdft_bin_addr, 0);
    check("rst_mid_start", sdft_start, 0);
    check("rst_mid_overrun", overrun, 0);
    repeat (4) @(posedge clk);
    #1; reset_n = 1'b1;
    repeat (60) @(posedge clk);
    check("rst_no_row_done", row_done_cnt - d0, 0);
    disp_read(0, 3, 8'd0);
    disp_read(5, 3, 8'd0);
    disp_done();
    check("overrun_after_rst", overrun, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
